uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter, next generation of the byte TX. Configurable data width, parity and
//  stop bits; valid/ready byte input with a one-entry holding buffer for back-to-back frames; runtime
//  baud select. Sits between the system-side producer (FIFO/CPU regs) and the serial pin.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency in Hz; baud divisors derive from it
//  DATA_BITS   8           data bits per frame, legal 5..8 (elaborate-time check)
//  PARITY      0           0 = none, 1 = odd, 2 = even
//  STOP_BITS   1           stop bits per frame, legal 1 or 2
// PORTS
//  clk         in   1          system clock
//  rst         in   1          asynchronous, active-high reset
//  baud_set    in   3          0=9600 1=19200 2=38400 3=57600 4=115200; 5..7 map to 9600
//  in_data     in   DATA_BITS  word to send, LSB transmitted first
//  in_valid    in   1          producer has a word
//  in_ready    out  1          holding buffer empty; transfer when in_valid & in_ready
//  tx          out  1          serial line, idle high
//  busy        out  1          a frame is on the line (start..last stop)
//  tx_done     out  1          one-cycle pulse at the end of the last stop bit
// BEHAVIOUR
//  Reset (async, rst=1): tx=1, busy=0, tx_done=0, in_ready=1, buffer empty, FSM IDLE, counters 0.
//  Asserting rst mid-frame aborts the frame immediately; no partial data is retained.
//  Divisor: DIV = round(CLK_FREQ/baud) - 1, 16-bit; one bit period = DIV+1 clk cycles.
//  baud_set is sampled only at frame start (IDLE->START); later changes do not affect the current frame.
//  Handshake: on in_valid & in_ready, in_data is captured into the buffer and in_ready drops next cycle.
//   in_data/in_valid are don't-care while in_ready=0. The buffer is freed (in_ready=1) in the cycle the
//   FSM loads it into the shift register, so a second word can be accepted during the current frame.
//  FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START when the buffer is full.
//   IDLE: tx=1. Leaves the cycle after the buffer becomes full; shift reg <= buffer, baud cnt <= 0.
//   START: tx=0 for one bit period. DATA: DATA_BITS periods, LSB first, bit index 0..DATA_BITS-1.
//   PARITY (PARITY!=0 only): even -> tx=^data; odd -> tx=~^data; one period.
//   STOP: tx=1 for STOP_BITS periods. tx_done pulses in the last cycle of the final stop period.
//   Back-to-back: if the buffer is full at end of STOP, the next START begins in the following cycle
//   with no idle gap; busy stays 1 and tx_done still pulses once per frame.
//  tx is registered: it changes exactly on bit-period boundaries, glitch-free.
//  Baud counter counts 0..DIV then wraps and emits a one-cycle tick; it is cleared at every frame start
//   and held at 0 in IDLE, so the first bit period is exactly DIV+1 cycles.
//  Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * (DIV+1) cycles.
//  in_valid asserted in the reset-release cycle is accepted normally on the next rising edge.
// STRUCTURE
//  Package uart_pkg: parity localparams (PAR_NONE/ODD/EVEN), baud table values, function
//   baud_div(clk_freq, baud_set) returning the 16-bit divisor; shared with the future uart_rx_param.
//  Sub-module uart_baud_gen: divisor lookup register + tick counter (clk, rst, clr, en, baud_set -> tick).
//  Top holds the buffer, shift register, bit counter, parity accumulator and FSM.
// TESTING (CLK_FREQ=50e6 unless stated)
//  1 8N1, baud_set=4 (DIV=433), send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1 each 434 clk; tx_done at 4340.
//  2 8E1, baud_set=0 (DIV=5207), send 0xA5 -> parity bit 0; send 0x01 -> parity 1; frame 11*5208 clk.
//  3 DATA_BITS=7, odd parity, 2 stop, send 7'h55 -> 1 start, 1010101, parity 1, 2 stops; 11 bit periods.
//  4 Back-to-back: in_valid held high with 0x11,0x22,0x33 -> accepted 2nd word during frame 1; no idle
//    gap between frames; 3 tx_done pulses; in_ready low while buffer full.
//  5 Change baud_set 4->0 mid-frame -> current frame stays 434 clk/bit; next frame uses 5208 clk/bit.
//  6 Assert rst mid DATA bit -> tx=1, busy=0, in_ready=1 same cycle; next send produces clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- constants, FSM state type and baud divisor helper shared by the UART TX/RX blocks. Rev 1.0
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int BAUD_9600   = 9600;
  localparam int BAUD_19200  = 19200;
  localparam int BAUD_38400  = 38400;
  localparam int BAUD_57600  = 57600;
  localparam int BAUD_115200 = 115200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic int baud_rate(input logic [2:0] sel);
    case (sel)
      3'd1:    return BAUD_19200;
      3'd2:    return BAUD_38400;
      3'd3:    return BAUD_57600;
      3'd4:    return BAUD_115200;
      default: return BAUD_9600;
    endcase
  endfunction

  // Rounded divisor minus one: one bit period is the returned value + 1 clocks.
  function automatic logic [15:0] baud_div(input int clk_freq, input logic [2:0] sel);
    int rate;
    rate = baud_rate(sel);
    return 16'((clk_freq + rate / 2) / rate - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// uart_baud_gen -- divisor latched at frame start plus bit-period tick counter. Rev 1.0
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [2:0] baud_set_i,
  output logic       tick_o
);

  localparam logic [15:0] DIV_0 = baud_div(CLK_FREQ, 3'd0);
  localparam logic [15:0] DIV_1 = baud_div(CLK_FREQ, 3'd1);
  localparam logic [15:0] DIV_2 = baud_div(CLK_FREQ, 3'd2);
  localparam logic [15:0] DIV_3 = baud_div(CLK_FREQ, 3'd3);
  localparam logic [15:0] DIV_4 = baud_div(CLK_FREQ, 3'd4);

  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q;

  always_comb begin
    case (baud_set_i)
      3'd1:    div_d = DIV_1;
      3'd2:    div_d = DIV_2;
      3'd3:    div_d = DIV_3;
      3'd4:    div_d = DIV_4;
      default: div_d = DIV_0;
    endcase
  end

  assign tick_o = en_i && (cnt_q == div_q);

  // The divisor only moves at frame start, so a mid-frame baud change waits for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_0;
      cnt_q <= '0;
    end else begin
      if (clr_i) begin
        div_q <= div_d;
      end
      if (clr_i || !en_i || tick_o) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// uart_tx_param -- parametrised UART transmitter with one-entry holding buffer and runtime baud select. Rev 1.0
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           baud_set,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 buf_full_q, buf_full_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_d;
  logic                 frame_start;
  logic                 baud_tick;

  uart_baud_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (frame_start),
    .en_i       (state_q != ST_IDLE),
    .baud_set_i (baud_set),
    .tick_o     (baud_tick)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    frame_start = 1'b0;

    if (in_valid && !buf_full_q) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (buf_full_q) begin
          frame_start = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = (PARITY == PAR_EVEN) ? par_q : ~par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            if (buf_full_q) begin
              frame_start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading the shift register frees the buffer for the next producer word.
    if (frame_start) begin
      state_d    = ST_START;
      shift_d    = buf_q;
      par_d      = ^buf_q;
      buf_full_d = 1'b0;
      tx_d       = 1'b0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  assign in_ready = ~buf_full_q;
  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign tx_done  = done_d;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// tb_uart_tx_param -- four parameter sets driven with random and directed words; every cycle the
// line, busy, tx_done and in_ready are compared with a frame-level timing model.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      if (n_fail >= 100) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  endtask

  // Bit period minus one, straight from the baud table with real-valued rounding.
  function automatic int ref_div(input int clk_freq, input int sel);
    int rate;
    case (sel)
      1:       rate = 19200;
      2:       rate = 38400;
      3:       rate = 57600;
      4:       rate = 115200;
      default: rate = 9600;
    endcase
    return $rtoi(real'(clk_freq) / real'(rate) + 0.5) - 1;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_cfg
    localparam int CF     = (k == 3) ? 50_000_000 : 1_152_000;
    localparam int DB     = (k == 1) ? 7 : 8;
    localparam int PA     = (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    localparam int SB     = (k == 1) ? 2 : 1;
    localparam int NFR    = (k == 3) ? 1 : 14;
    localparam int BAUD_B = (k == 3) ? 3 : 0;

    logic          rst      = 1'b1;
    logic [2:0]    baud_set = 3'd4;
    logic [DB-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, tx, busy, tx_done;
    bit            done_flag = 1'b0;

    uart_tx_param #(
      .CLK_FREQ (CF),
      .DATA_BITS(DB),
      .PARITY   (PA),
      .STOP_BITS(SB)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .baud_set(baud_set),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done)
    );

    // Accepted words with the edge number on which they were taken.
    logic [7:0]  q_data[$];
    int unsigned q_acc[$];
    bit          act      = 1'b0;
    int unsigned fs       = 0;
    int unsigned flen     = 0;
    int unsigned fdiv     = 0;
    int unsigned prev_end = 0;
    bit          fbits[$];

    initial begin
      logic [7:0]  d;
      logic [3:0]  e;
      bit          p;
      int unsigned s;
      int unsigned idx;
      forever begin
        @(posedge clk);
        #1;
        if (rst) begin
          q_data.delete();
          q_acc.delete();
          act      = 1'b0;
          prev_end = 0;
          e        = 4'b1001;
        end else begin
          if (!act && q_data.size() > 0) begin
            s = (q_acc[0] + 1 > prev_end) ? q_acc[0] + 1 : prev_end;
            if (cyc >= s) begin
              d = q_data.pop_front();
              void'(q_acc.pop_front());
              fdiv = ref_div(CF, int'(baud_set));
              fbits.delete();
              fbits.push_back(1'b0);
              p = 1'b0;
              for (int i = 0; i < DB; i++) begin
                fbits.push_back(d[i]);
                p ^= d[i];
              end
              if (PA == 2) fbits.push_back(p);
              if (PA == 1) fbits.push_back(~p);
              for (int i = 0; i < SB; i++) fbits.push_back(1'b1);
              flen = fbits.size() * (fdiv + 1);
              fs   = cyc;
              act  = 1'b1;
            end
          end
          if (act) begin
            idx = (cyc - fs) / (fdiv + 1);
            e   = {fbits[idx], 1'b1, (cyc - fs == flen - 1), (q_data.size() == 0)};
            if (cyc - fs == flen - 1) begin
              act      = 1'b0;
              prev_end = fs + flen;
            end
          end else begin
            e = {1'b1, 1'b0, 1'b0, (q_data.size() == 0)};
          end
        end
        check_eq($sformatf("cfg%0d {tx,busy,tx_done,in_ready}", k),
                 {28'd0, tx, busy, tx_done, in_ready}, {28'd0, e});
      end
    end

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic send(input logic [7:0] d, input bit hold);
      int w;
      in_data  = d[DB-1:0];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20000) begin
        @(negedge clk);
        w++;
      end
      check_eq($sformatf("cfg%0d ready_wait", k), {31'd0, in_ready}, 32'd1);
      if (in_ready) begin
        q_data.push_back(d);
        q_acc.push_back(cyc + 1);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        check_eq($sformatf("cfg%0d ready_drop", k), {31'd0, in_ready}, 32'd0);
      end else begin
        in_valid = 1'b0;
      end
    endtask

    task automatic drain();
      int w;
      w = 0;
      while ((act || q_data.size() != 0) && w < 60000) begin
        @(negedge clk);
        w++;
      end
      check_eq($sformatf("cfg%0d drain", k), {31'd0, (act || q_data.size() != 0)}, 32'd0);
      repeat (3) @(negedge clk);
    endtask

    initial begin
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      baud_set = 3'd4;
      send((k == 1) ? 8'h55 : 8'hA5, 1'b0);
      if (k == 2) send(8'h01, 1'b0);

      for (int n = 0; n < NFR; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        baud_set = (k == 3) ? 3'd4 : 3'($urandom_range(0, 7));
        send(8'($urandom), 1'b0);
      end
      drain();

      baud_set = 3'd4;
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      send(8'h33, 1'b0);
      drain();

      baud_set = 3'd4;
      send(8'($urandom), 1'b0);
      repeat (30) @(negedge clk);
      baud_set = 3'(BAUD_B);
      send(8'($urandom), 1'b0);
      drain();

      baud_set = 3'd4;
      send(8'($urandom), 1'b0);
      repeat ((ref_div(CF, 4) + 1) * 3 / 2) @(negedge clk);
      check_eq($sformatf("cfg%0d busy_before_rst", k), {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq($sformatf("cfg%0d rst_tx", k), {31'd0, tx}, 32'd1);
      check_eq($sformatf("cfg%0d rst_busy", k), {31'd0, busy}, 32'd0);
      check_eq($sformatf("cfg%0d rst_ready", k), {31'd0, in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send(8'($urandom), 1'b0);
      drain();
      done_flag = 1'b1;
    end
  end

  initial begin
    int w;
    logic [3:0] all_done;
    w = 0;
    all_done = 4'h0;
    while (all_done != 4'hF && w < 95000) begin
      @(negedge clk);
      w++;
      all_done = {g_cfg[3].done_flag, g_cfg[2].done_flag, g_cfg[1].done_flag, g_cfg[0].done_flag};
    end
    check_eq("all_cfg_done", {28'd0, all_done}, 32'hF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
